ts_packet_selector: RTL and testbench
=====================================

# ts_packet_selector

Parametrised N-channel MPEG2-TS stream selector with packet-aligned switching, replacing the free-running 4:1 byte mux in front of the output FIFO. It forwards one channel's byte/valid/sync stream and switches to a newly requested channel only at a packet boundary. It resynchronises on sync, flags framing errors, and drives a registered 9-bit-compatible stream into the downstream `fifo_controller` write side.

## Interface

- `NUM_CH`, 4: number of input TS channels, 2..16.
- `SEL_W`, `$clog2(NUM_CH)`: width of `sel` and `active_ch`.
- `PKT_LEN`, 188: bytes per TS packet, including the sync byte.
- `CNT_W`, 16: width of the statistics counters.

Ports:

- `clk`, in, 1: single clock. All ports are synchronous to it.
- `rstn`, in, 1: asynchronous, active-low reset.
- `sel`, in, SEL_W: requested channel.
- `data_in`, in, NUM_CH*8: channel k is `data_in[8k+7:8k]`.
- `valid_in`, in, NUM_CH: per-channel byte valid.
- `sync_in`, in, NUM_CH: per-channel packet-start flag, meaningful only with valid.
- `data_out`, out, 8: forwarded byte.
- `valid_out`, out, 1: `data_out` valid.
- `sync_out`, out, 1: first byte of a packet.
- `active_ch`, out, SEL_W: channel currently locked.
- `locked`, out, 1: high in PASS state.
- `err_sync`, out, 1: one-cycle pulse on a framing error.
- `pkt_cnt`, out, CNT_W: present only with the statistics macro.
- `drop_cnt`, out, CNT_W: present only with the statistics macro.

## Operation

- Two-state FSM with states SEEK and PASS, plus a byte counter `byte_cnt` in the range 0..PKT_LEN-1.
- **SEEK.**
  - Target is `sel`, sampled every cycle. `valid_out` is 0.
  - On `valid_in[sel] & sync_in[sel]`:
    - `active_ch <= sel` and `byte_cnt <= 1`.
    - Emit the byte with `sync_out = 1`.
    - Go to PASS.
  - Bytes without sync are discarded.
- **PASS.** Forward each valid byte of `active_ch`. `byte_cnt` increments per valid byte. Non-valid cycles give `valid_out = 0` and the counter holds.
- **Last byte** (`byte_cnt == PKT_LEN-1` and valid): the byte is forwarded and `byte_cnt <= 0`.
  - If `sel != active_ch`, go to SEEK; the switch takes effect on the new channel's next sync.
  - Otherwise stay in PASS.
- **Expected start** (`byte_cnt == 0`):
  - A valid byte without sync is dropped.
  - `err_sync` pulses and the FSM goes to SEEK, so lock is lost.
- **Early sync** (sync with `byte_cnt != 0`):
  - `err_sync` pulses.
  - The byte is forwarded as a new packet start with `sync_out = 1` and `byte_cnt <= 1`; the FSM realigns.
- **Channel changes:**
  - A `sel` change mid-packet is ignored until the packet ends.
  - If `sel` returns to `active_ch` before the packet ends, no switch occurs.
  - `sel >= NUM_CH` is treated as no channel: the block finishes the current packet, then stays in SEEK with no output.
- Inputs of non-active channels are ignored entirely.

## Timing

- Registered outputs with 1-cycle latency: an input accepted at edge n appears at edge n+1.
- After a switch, the first output byte of the new channel is its sync byte. No mixed-channel packet is ever emitted.
- Back-to-back packets on the same channel need zero idle cycles.
- Reset values (async assert, sync deassert):
  - state = SEEK.
  - `active_ch = 0`.
  - `data_out = 0`, `valid_out = 0`, `sync_out = 0`.
  - `locked = 0`, `err_sync = 0`.
  - `byte_cnt = 0`.
  - counters = 0.
- Reset mid-packet aborts the packet. No partial byte is emitted after reset release.
- `err_sync` and a forwarded byte can occur in the same cycle (early-sync case).

## Configuration

- `TS_SEL_STATS_EN` defined:
  - `pkt_cnt` increments on every forwarded last byte (`byte_cnt == PKT_LEN-1`).
  - `drop_cnt` increments on every `err_sync` pulse.
  - Both counters wrap at 2^CNT_W.
- `TS_SEL_STATS_EN` undefined: both ports and their counters are absent.

## Structure

- Shared package `ts_pkg`:
  - `TS_PKT_LEN = 188` and `TS_SYNC_BYTE = 8'h47`.
  - FSM state typedef `ts_sel_state_t` (SEEK, PASS).
- One sub-module, `ts_pkt_tracker`:
  - Contains the byte counter with valid/sync inputs.
  - Outputs `last_byte`, `expect_start` and `early_sync`.
  - Reused later by the output-side QoS monitor.

## Test plan

- **Lock:** reset, `sel = 0`, channel 0 sends 188-byte packets starting mid-packet.
  - Output stays silent until the first sync.
  - Then all 188 bytes appear 1 cycle delayed, with `sync_out` on byte 0 only.
- **Aligned switch:** `sel` goes 0→2 at byte 50 of a channel-0 packet.
  - Channel 0 bytes 50..187 are forwarded.
  - The next output is channel 2's sync byte.
  - `active_ch = 2` appears on that cycle; no channel-2 byte precedes it.
- **Early sync:** sync on byte 100 of a channel-1 packet.
  - `err_sync` pulses once.
  - Output shows `sync_out` on that byte, and the next packet boundary is 188 bytes later.
- **Missing sync:** on channel 3, byte 188 arrives without sync.
  - `err_sync` pulses, `locked` falls, and the byte is dropped.
  - The block relocks on the next sync.
- **Invalid select / gaps:**
  - With `NUM_CH = 4`, `sel = 5` after a packet gives no output.
  - Random `valid_in` gaps within a packet do not advance `byte_cnt` and give `valid_out = 0`.
- **Stats** (`TS_SEL_STATS_EN`): 3 good packets plus 1 early sync give `pkt_cnt = 3` and `drop_cnt = 1`. Asserting reset mid-run zeroes both counters immediately.

Source files
------------

// File: rtl/ts_pkg.sv
// Purpose: shared MPEG2-TS constants and selector FSM state type.
// Latency: n/a (package only).
// Backpressure: n/a.
package ts_pkg;

    localparam int         TS_PKT_LEN   = 188;
    localparam logic [7:0] TS_SYNC_BYTE = 8'h47;

    typedef enum logic {
        SEEK = 1'b0,
        PASS = 1'b1
    } ts_sel_state_t;

endpackage

// File: rtl/ts_pkt_tracker.sv
// Purpose: TS packet byte-position tracker; flags last byte, expected start and early sync.
// Latency: flags are combinational from the current count; the count updates on the clock.
// Backpressure: none; the count advances only on enabled valid bytes.
//
// Ports: clk/rstn; en gates counting; vld/sync describe the current byte;
//        last_byte, expect_start, early_sync describe that byte's position.
module ts_pkt_tracker
    import ts_pkg::*;
#(
    parameter int PKT_LEN = TS_PKT_LEN
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic vld,
    input  logic sync,
    output logic last_byte,
    output logic expect_start,
    output logic early_sync
);

    localparam int              BC_W = $clog2(PKT_LEN);
    localparam logic [BC_W-1:0] LAST = BC_W'(PKT_LEN - 1);

    logic [BC_W-1:0] byte_cnt;

    // A sync always restarts the packet at position 1. A non-sync byte at
    // position 0 is a missing sync: the count stays at 0 and the owner drops it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byte_cnt <= '0;
        end else if (en && vld) begin
            if (sync)
                byte_cnt <= BC_W'(1);
            else if (byte_cnt == LAST)
                byte_cnt <= '0;
            else if (byte_cnt != '0)
                byte_cnt <= byte_cnt + 1'b1;
        end
    end

    // A sync landing on the last position counts as early, not as last.
    assign expect_start = (byte_cnt == '0);
    assign early_sync   = vld && sync && (byte_cnt != '0);
    assign last_byte    = vld && !sync && (byte_cnt == LAST);

endmodule

// File: rtl/ts_packet_selector.sv
// Purpose: N-channel TS selector that switches channel only on packet boundaries.
// Latency: 1 cycle, input byte accepted at edge n is on the outputs after edge n.
// Backpressure: none; bytes of the locked channel are forwarded as they arrive.
//
// Ports: sel picks the requested channel; data_in/valid_in/sync_in carry NUM_CH
//        byte streams (channel k in data_in[8k+7:8k]); data_out/valid_out/sync_out
//        is the registered selected stream; active_ch/locked show lock status;
//        err_sync pulses on framing errors. Optional macro TS_SEL_STATS_EN adds
//        pkt_cnt (completed packets) and drop_cnt (framing errors).
module ts_packet_selector
    import ts_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int SEL_W   = $clog2(NUM_CH),
    parameter int PKT_LEN = TS_PKT_LEN,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [SEL_W-1:0]    sel,
    input  logic [NUM_CH*8-1:0] data_in,
    input  logic [NUM_CH-1:0]   valid_in,
    input  logic [NUM_CH-1:0]   sync_in,
    output logic [7:0]          data_out,
    output logic                valid_out,
    output logic                sync_out,
    output logic [SEL_W-1:0]    active_ch,
    output logic                locked,
    output logic                err_sync
`ifdef TS_SEL_STATS_EN
    ,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    drop_cnt
`endif
);

    // Inputs are zero-padded to the full select range so a select value with
    // no channel behind it reads as a permanently idle channel.
    localparam int NPAD = 1 << SEL_W;

    ts_sel_state_t   state, next_state;
    logic [NPAD-1:0]   vld_pad, syn_pad;
    logic [NPAD*8-1:0] dat_pad;
    logic [SEL_W-1:0]  ch_idx;
    logic              ch_vld, ch_syn, lock_hit;
    logic [7:0]        ch_dat;
    logic              trk_en, last_byte, expect_start, early_sync;
    logic              fwd, fwd_sync, err;

    assign vld_pad = NPAD'(valid_in);
    assign syn_pad = NPAD'(sync_in);
    assign dat_pad = (NPAD*8)'(data_in);

    // While seeking, the live request is the target; once locked, only the
    // locked channel is looked at.
    assign ch_idx   = (state == SEEK) ? sel : active_ch;
    assign ch_vld   = vld_pad[ch_idx];
    assign ch_syn   = syn_pad[ch_idx];
    assign ch_dat   = dat_pad[{ch_idx, 3'b000} +: 8];
    assign lock_hit = ch_vld && ch_syn;
    assign locked   = (state == PASS);

    ts_pkt_tracker #(
        .PKT_LEN (PKT_LEN)
    ) u_tracker (
        .clk          (clk),
        .rstn         (rstn),
        .en           (trk_en),
        .vld          (ch_vld),
        .sync         (ch_syn),
        .last_byte    (last_byte),
        .expect_start (expect_start),
        .early_sync   (early_sync)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= SEEK;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            SEEK: if (lock_hit) next_state = PASS;
            PASS: begin
                if (ch_vld && expect_start && !ch_syn)
                    next_state = SEEK;
                else if (last_byte && (sel != active_ch))
                    next_state = SEEK;
            end
            default: next_state = SEEK;
        endcase
    end

    always_comb begin
        trk_en   = 1'b0;
        fwd      = 1'b0;
        fwd_sync = 1'b0;
        err      = 1'b0;
        case (state)
            SEEK: begin
                trk_en   = lock_hit;
                fwd      = lock_hit;
                fwd_sync = 1'b1;
            end
            PASS: begin
                trk_en = 1'b1;
                if (ch_vld) begin
                    if (expect_start && !ch_syn) begin
                        err = 1'b1;
                    end else begin
                        fwd      = 1'b1;
                        fwd_sync = ch_syn;
                        err      = early_sync;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out  <= '0;
            valid_out <= 1'b0;
            sync_out  <= 1'b0;
            err_sync  <= 1'b0;
            active_ch <= '0;
        end else begin
            valid_out <= fwd;
            sync_out  <= fwd && fwd_sync;
            err_sync  <= err;
            if (fwd)
                data_out <= ch_dat;
            if ((state == SEEK) && lock_hit)
                active_ch <= sel;
        end
    end

`ifdef TS_SEL_STATS_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if ((state == PASS) && last_byte)
                pkt_cnt <= pkt_cnt + 1'b1;
            if (err)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    // Statistics build option off: no counters.
`endif

endmodule

// File: tb/tb_ts_packet_selector.sv
// Purpose: directed self-checking bench for ts_packet_selector (4 channels, 3-bit select).
// Latency: checks outputs 1 ns after each rising edge against bytes driven in the previous cycle.
// Backpressure: n/a; non-selected channels carry random traffic that must be ignored.
module tb_ts_packet_selector;
    import ts_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int SEL_W   = 3;
    localparam int PKT_LEN = 188;
    localparam int CNT_W   = 16;

    logic                clk = 1'b0;
    logic                rstn;
    logic [SEL_W-1:0]    sel;
    logic [NUM_CH*8-1:0] data_in;
    logic [NUM_CH-1:0]   valid_in;
    logic [NUM_CH-1:0]   sync_in;
    logic [7:0]          data_out;
    logic                valid_out;
    logic                sync_out;
    logic [SEL_W-1:0]    active_ch;
    logic                locked;
    logic                err_sync;
`ifdef TS_SEL_STATS_EN
    logic [CNT_W-1:0]    pkt_cnt;
    logic [CNT_W-1:0]    drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ts_packet_selector #(
        .NUM_CH  (NUM_CH),
        .SEL_W   (SEL_W),
        .PKT_LEN (PKT_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .sel       (sel),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .sync_in   (sync_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .sync_out  (sync_out),
        .active_ch (active_ch),
        .locked    (locked),
        .err_sync  (err_sync)
`ifdef TS_SEL_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    function automatic logic [7:0] pat(input int ch, input int idx);
        if (idx == 0)
            return TS_SYNC_BYTE;
        return 8'((ch * 61 + idx * 3 + 1) & 255);
    endfunction

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Random traffic on every channel; the caller then overrides the channel under test.
    task automatic noise();
        data_in  = $urandom;
        valid_in = 4'($urandom);
        sync_in  = 4'($urandom);
    endtask

    task automatic put(input int ch, input int idx, input bit sy);
        data_in[ch*8 +: 8] = pat(ch, idx);
        valid_in[ch]       = 1'b1;
        sync_in[ch]        = sy;
    endtask

    // Send bytes first..last of channel ch (sync on index 0), checking each output.
    task automatic pkt_send(input int ch, input int first, input int last,
                            input bit exp_fwd, input string tag);
        for (int i = first; i <= last; i++) begin
            noise();
            put(ch, i, i == 0);
            cyc();
            chk(32'(valid_out), 32'(exp_fwd), {tag, ".valid"});
            if (exp_fwd) begin
                chk(32'(data_out), 32'(pat(ch, i)), {tag, ".data"});
                chk(32'(sync_out), 32'(i == 0), {tag, ".sync"});
            end
            chk(32'(err_sync), 32'd0, {tag, ".err"});
        end
    endtask

    initial begin
        rstn     = 1'b0;
        sel      = '0;
        data_in  = '0;
        valid_in = '0;
        sync_in  = '0;
        repeat (3) cyc();

        // Reset state
        chk(32'(valid_out), 32'd0, "rst.valid");
        chk(32'(sync_out),  32'd0, "rst.sync");
        chk(32'(data_out),  32'd0, "rst.data");
        chk(32'(locked),    32'd0, "rst.locked");
        chk(32'(err_sync),  32'd0, "rst.err");
        chk(32'(active_ch), 32'd0, "rst.active_ch");
`ifdef TS_SEL_STATS_EN
        chk(32'(pkt_cnt),   32'd0, "rst.pkt_cnt");
        chk(32'(drop_cnt),  32'd0, "rst.drop_cnt");
`endif
        rstn = 1'b1;

        // Lock: join channel 0 mid-packet, silent until its sync
        sel = 3'd0;
        pkt_send(0, 100, 187, 1'b0, "lock.pre");
        chk(32'(locked), 32'd0, "lock.pre_locked");
        pkt_send(0, 0, 187, 1'b1, "lock.pkt");
        chk(32'(locked),    32'd1, "lock.locked");
        chk(32'(active_ch), 32'd0, "lock.active_ch");

        // Aligned switch 0 -> 2 at byte 50
        pkt_send(0, 0, 49, 1'b1, "sw.head");
        sel = 3'd2;
        pkt_send(0, 50, 187, 1'b1, "sw.tail");
        chk(32'(locked), 32'd0, "sw.unlocked");
        for (int j = 0; j <= 8; j++) begin
            noise();
            put(0, j, j == 0);
            if (j < 8) put(2, 180 + j, 1'b0);
            else       put(2, 0, 1'b1);
            cyc();
            if (j < 8) begin
                chk(32'(valid_out), 32'd0, "sw.gap_valid");
                chk(32'(active_ch), 32'd0, "sw.gap_active");
            end else begin
                chk(32'(valid_out), 32'd1, "sw.new_valid");
                chk(32'(sync_out),  32'd1, "sw.new_sync");
                chk(32'(data_out),  32'(TS_SYNC_BYTE), "sw.new_data");
                chk(32'(active_ch), 32'd2, "sw.new_active");
            end
        end

        // Select wanders away and back mid-packet: no switch
        pkt_send(2, 1, 19, 1'b1, "ret.a");
        sel = 3'd1;
        pkt_send(2, 20, 59, 1'b1, "ret.b");
        sel = 3'd2;
        pkt_send(2, 60, 187, 1'b1, "ret.c");
        chk(32'(locked), 32'd1, "ret.locked");
        pkt_send(2, 0, 9, 1'b1, "ret.d");
        sel = 3'd1;
        pkt_send(2, 10, 187, 1'b1, "ret.e");

        // Early sync on byte 100 of channel 1 (locks with zero idle cycles)
        pkt_send(1, 0, 99, 1'b1, "early.head");
        chk(32'(active_ch), 32'd1, "early.active");
        noise();
        put(1, 0, 1'b1);
        cyc();
        chk(32'(valid_out), 32'd1, "early.valid");
        chk(32'(sync_out),  32'd1, "early.sync");
        chk(32'(err_sync),  32'd1, "early.err");
        chk(32'(data_out),  32'(TS_SYNC_BYTE), "early.data");
        pkt_send(1, 1, 187, 1'b1, "early.realigned");
        sel = 3'd3;
        pkt_send(1, 0, 187, 1'b1, "early.next");

        // Missing sync on channel 3
        pkt_send(3, 0, 187, 1'b1, "miss.pkt");
        chk(32'(active_ch), 32'd3, "miss.active");
        noise();
        put(3, 5, 1'b0);
        cyc();
        chk(32'(valid_out), 32'd0, "miss.drop");
        chk(32'(err_sync),  32'd1, "miss.err");
        chk(32'(locked),    32'd0, "miss.locked");
        noise();
        put(3, 6, 1'b0);
        cyc();
        chk(32'(err_sync),  32'd0, "miss.err_pulse");
        chk(32'(valid_out), 32'd0, "miss.seek");
        pkt_send(3, 0, 187, 1'b1, "miss.relock");
        chk(32'(locked), 32'd1, "miss.relocked");

        // Select with no channel behind it
        sel = 3'd5;
        pkt_send(3, 0, 187, 1'b1, "inv.finish");
        pkt_send(3, 0, 19, 1'b0, "inv.silent");
        chk(32'(locked),    32'd0, "inv.locked");
        chk(32'(active_ch), 32'd3, "inv.active");

        // Valid gaps inside a channel 0 packet
        sel = 3'd0;
        for (int i = 0; i < PKT_LEN; i++) begin
            if (i % 17 == 5) begin
                repeat ($urandom_range(1, 2)) begin
                    noise();
                    valid_in[0] = 1'b0;
                    cyc();
                    chk(32'(valid_out), 32'd0, "gap.idle");
                end
            end
            noise();
            put(0, i, i == 0);
            cyc();
            chk(32'(valid_out), 32'd1, "gap.valid");
            chk(32'(data_out),  32'(pat(0, i)), "gap.data");
            chk(32'(sync_out),  32'(i == 0), "gap.sync");
        end
        pkt_send(0, 0, 49, 1'b1, "gap.boundary");

        // Reset mid-packet aborts it
        noise();
        put(0, 50, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk(32'(valid_out), 32'd0, "arst.valid");
        chk(32'(data_out),  32'd0, "arst.data");
        chk(32'(locked),    32'd0, "arst.locked");
        cyc();
        rstn = 1'b1;
        pkt_send(0, 51, 187, 1'b0, "arst.partial");

        // Three good packets then an early sync
        pkt_send(0, 0, 187, 1'b1, "stat.p1");
        pkt_send(0, 0, 187, 1'b1, "stat.p2");
        pkt_send(0, 0, 187, 1'b1, "stat.p3");
        pkt_send(0, 0, 99, 1'b1, "stat.p4");
        noise();
        put(0, 0, 1'b1);
        cyc();
        chk(32'(err_sync), 32'd1, "stat.err");
        pkt_send(0, 1, 10, 1'b1, "stat.after");
`ifdef TS_SEL_STATS_EN
        chk(32'(pkt_cnt),  32'd3, "stat.pkt_cnt");
        chk(32'(drop_cnt), 32'd1, "stat.drop_cnt");
`endif
        #2;
        rstn = 1'b0;
        #1;
        chk(32'(valid_out), 32'd0, "arst2.valid");
        chk(32'(locked),    32'd0, "arst2.locked");
`ifdef TS_SEL_STATS_EN
        chk(32'(pkt_cnt),  32'd0, "arst2.pkt_cnt");
        chk(32'(drop_cnt), 32'd0, "arst2.drop_cnt");
`endif
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
